id_ex_pipe: RTL
===============

# id_ex_pipe

Parametrised ID/EX pipeline stage for the RISC-V core. It sits between decode and execute and carries the decoded instruction payload with a valid/ready handshake. A two-entry skid buffer lets it absorb a one-cycle downstream stall without loss. It also supports synchronous flush (branch redirect) and detects load-use hazards, emitting a bubble with all control bits zeroed.

## Interface
Parameters:
- XLEN, 64, width of PC, operand and immediate fields
- REG_AW, 5, register-address width
- CTRL_W, 9, control bundle width {MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc, ALU_op[1:0], spare}
- MEMREAD_BIT, 4, index of MemRead inside the control bundle
- FUNCT_W, 7, width of packed {funct_in[3:0], func3[2:0]}

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all held and incoming entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc, in_rd1, in_rd2, in_imm  in  XLEN each  payload
- in_funct  in  FUNCT_W  payload
- in_rd, in_rs1, in_rs2  in  REG_AW each  register addresses
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute accepts
- out_* (pc, rd1, rd2, imm, funct, rd, rs1, rs2, ctrl)  out  same widths as the in_* fields
- hazard  out  1  load-use stall active (combinational)

## Operation
- Storage: a main register (drives out_*) and a skid register, each with its own valid bit.
- in_ready = !skid_valid && !hazard.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Main empty, or being emitted, on accept: load main directly.
- Main full and not emitted on accept: load skid; in_ready drops next cycle.
- Main emitted while skid holds data: skid moves to main and the skid is cleared. A concurrent accept is impossible because in_ready is 0.
- hazard = in_valid && out_valid && out_ctrl[MEMREAD_BIT] && out_rd != 0 && (out_rd == in_rs1 || out_rd == in_rs2).
- While hazard is active, the input is not accepted. When main is emitted, it refills as a bubble: valid = 0, ctrl = 0.
- flush: both valid bits clear and both ctrl fields are zeroed at the next edge. Any same-cycle accept is discarded. flush has priority over every other event.
- out_ctrl is forced to 0 whenever out_valid = 0, so downstream never sees a write enable on a bubble.
- Data fields are not cleared on bubble or flush; only valid and ctrl are cleared.

## Timing
- Latency: 1 cycle from accept to out_valid when main is empty.
- Throughput: 1 per cycle with out_ready held high.
- Reset values: main and skid valid = 0, every out_* = 0, out_valid = 0, in_ready = 1, hazard = 0.
- Reset asserted mid-transfer drops all entries immediately, without waiting for a clock edge.
- Payload must be held stable by the sender while in_valid && !in_ready. out_* are held stable while out_valid && !out_ready.
- hazard and in_ready are combinational from in_* and the main register; there is no combinational path from out_ready to in_ready.
- rd = x0 never raises hazard.

## Structure
- Package riscv_pipe_pkg holds: control-bundle bit indices (including MEMREAD_BIT), CTRL_W, REG_AW, FUNCT_W, and a packed id_ex_payload_t struct.
- One sub-module, pipe_skid_reg: a generic valid/ready two-entry skid register over a packed payload with a clear input. id_ex_pipe wraps it and adds the hazard logic and control zeroing.

## Test plan
- Stream 8 instructions with out_ready = 1 -> outputs appear 1 cycle after each accept in order; in_ready stays 1.
- Hold out_ready = 0 for 3 cycles during streaming -> skid fills, in_ready = 0 from the second held cycle; on release, order is preserved with no drop or duplicate.
- Main holds ld with rd = 5 and MemRead = 1; next instruction has rs2 = 5 -> hazard = 1, one bubble cycle (out_valid = 0, out_ctrl = 0), then the dependent instruction issues.
- Same as the previous case but rd = 0 -> hazard = 0, no bubble.
- flush with main and skid full and in_valid = 1 -> next cycle out_valid = 0 and in_ready = 1; the flushed instruction never appears at the output.
- Assert rst_n low between clock edges with data held -> out_valid and out_ctrl go to 0 immediately; after release, in_ready = 1.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared widths, control-bundle bit positions and the ID/EX payload layout
// for the RISC-V pipeline registers.
package riscv_pipe_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned CTRL_W  = 9;
   localparam int unsigned FUNCT_W = 7;

   // Control bundle: {MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc, ALU_op[1:0], spare}
   localparam int unsigned MEMTOREG_BIT = 8;
   localparam int unsigned REGWRITE_BIT = 7;
   localparam int unsigned BRANCH_BIT   = 6;
   localparam int unsigned MEMWRITE_BIT = 5;
   localparam int unsigned MEMREAD_BIT  = 4;
   localparam int unsigned ALUSRC_BIT   = 3;
   localparam int unsigned ALUOP_HI_BIT = 2;
   localparam int unsigned ALUOP_LO_BIT = 1;
   localparam int unsigned SPARE_BIT    = 0;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    rd1;
      logic [XLEN-1:0]    rd2;
      logic [XLEN-1:0]    imm;
      logic [FUNCT_W-1:0] funct;
      logic [REG_AW-1:0]  rd;
      logic [REG_AW-1:0]  rs1;
      logic [REG_AW-1:0]  rs2;
      logic [CTRL_W-1:0]  ctrl;
   } id_ex_payload_t;

   localparam int unsigned ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry valid/ready skid register: a main entry driving the
// output and a skid entry that catches one accept while main is stalled.
module pipe_skid_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid, main_valid_d;
   logic         skid_valid, skid_valid_d;
   logic [W-1:0] main_data, skid_data;
   logic         accept_c, emit_c;
   logic         load_main_in, load_main_skid, load_skid;

   // Next-state: clear wins; a free or draining main takes skid first, then input.
   always_comb begin
      main_valid_d   = main_valid;
      skid_valid_d   = skid_valid;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      accept_c       = in_valid && !skid_valid;
      emit_c         = main_valid && out_ready;
      if (clear) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid || emit_c) begin
         if (skid_valid) begin
            load_main_skid = 1'b1;
            main_valid_d   = 1'b1;
            skid_valid_d   = 1'b0;
         end else begin
            load_main_in = accept_c;
            main_valid_d = accept_c;
         end
      end else if (accept_c) begin
         load_skid    = 1'b1;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         if (load_main_skid)    main_data <= skid_data;
         else if (load_main_in) main_data <= in_data;
         if (load_skid)         skid_data <= in_data;
      end
   end

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: skid-buffered decode payload with load-use hazard
// detection, flush, and control zeroing on bubbles.
module id_ex_pipe #(
   parameter int unsigned XLEN        = riscv_pipe_pkg::XLEN,
   parameter int unsigned REG_AW      = riscv_pipe_pkg::REG_AW,
   parameter int unsigned CTRL_W      = riscv_pipe_pkg::CTRL_W,
   parameter int unsigned MEMREAD_BIT = riscv_pipe_pkg::MEMREAD_BIT,
   parameter int unsigned FUNCT_W     = riscv_pipe_pkg::FUNCT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [XLEN-1:0]    in_rd1,
   input  logic [XLEN-1:0]    in_rd2,
   input  logic [XLEN-1:0]    in_imm,
   input  logic [FUNCT_W-1:0] in_funct,
   input  logic [REG_AW-1:0]  in_rd,
   input  logic [REG_AW-1:0]  in_rs1,
   input  logic [REG_AW-1:0]  in_rs2,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_rd1,
   output logic [XLEN-1:0]    out_rd2,
   output logic [XLEN-1:0]    out_imm,
   output logic [FUNCT_W-1:0] out_funct,
   output logic [REG_AW-1:0]  out_rd,
   output logic [REG_AW-1:0]  out_rs1,
   output logic [REG_AW-1:0]  out_rs2,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic               hazard
);

   localparam int unsigned PAYLOAD_W = 4*XLEN + FUNCT_W + 3*REG_AW + CTRL_W;

   logic [PAYLOAD_W-1:0] in_data, main_data;
   logic [CTRL_W-1:0]    main_ctrl;
   logic                 skid_ready, main_valid;

   assign in_data = {in_pc, in_rd1, in_rd2, in_imm, in_funct,
                     in_rd, in_rs1, in_rs2, in_ctrl};

   // Load-use: a load in main whose destination feeds the incoming instruction.
   assign hazard = in_valid && main_valid && main_ctrl[MEMREAD_BIT]
                   && (out_rd != '0) && ((out_rd == in_rs1) || (out_rd == in_rs2));

   assign in_ready = skid_ready && !hazard;

   pipe_skid_reg #(
      .W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .in_valid  (in_valid && !hazard),
      .in_ready  (skid_ready),
      .in_data   (in_data),
      .out_valid (main_valid),
      .out_ready (out_ready),
      .out_data  (main_data)
   );

   assign {out_pc, out_rd1, out_rd2, out_imm, out_funct,
           out_rd, out_rs1, out_rs2, main_ctrl} = main_data;

   // Bubbles and flushed slots never present live control bits downstream.
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule
